// File: rtl/seq_priority_encoder_pkg.sv
// Shared definitions for seq_priority_encoder: FSM state encodings used by the
// block and its bench.
package seq_priority_encoder_pkg;

    typedef enum logic [1:0] {
        PENC_IDLE = 2'd0,
        PENC_SCAN = 2'd1,
        PENC_ZERO = 2'd2
    } penc_state_e;

endpackage

// File: rtl/seq_priority_encoder_lsb_first_encoder.sv
// lsb_first_encoder: combinational lowest-set-bit encoder. Also reports when
// exactly one bit of the vector is set.
module lsb_first_encoder #(
    parameter  int N_IN  = 16,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  pend,
    output logic [IDX_W-1:0] idx,
    output logic             single
);

    logic [N_IN-1:0] pend_low_cleared;

    // v & (v-1) drops the lowest set bit; nothing left means exactly one bit was set.
    assign pend_low_cleared = pend & (pend - N_IN'(1));
    assign single           = (|pend) & ~(|pend_low_cleared);

    always_comb begin
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: accepts an N_IN-bit request vector and emits the index of
// every set bit, lowest first, one per beat. Define PENC_COUNT_EN to add out_cnt.
//
// state     | meaning
// PENC_IDLE | waiting for a vector; in_ready follows enable
// PENC_SCAN | emitting indices of pend, lowest first
// PENC_ZERO | emitting the single out_none beat of an all-zero vector
module seq_priority_encoder
    import seq_priority_encoder_pkg::*;
#(
    parameter  int N_IN  = 16,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
`ifdef PENC_COUNT_EN
    ,
    output logic [IDX_W:0]   out_cnt
`endif
);

    penc_state_e      state, state_nxt;
    logic [N_IN-1:0]  pend, pend_nxt;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_single;
    logic             accept;

    lsb_first_encoder #(.N_IN(N_IN)) u_enc (
        .pend   (pend),
        .idx    (enc_idx),
        .single (enc_single)
    );

    // rst_n gates in_ready so nothing is offered while reset is held.
    assign in_ready = rst_n & enable & (state == PENC_IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PENC_IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        case (state)
            PENC_IDLE: begin
                if (accept) begin
                    if (|in_vec) begin
                        pend_nxt  = in_vec;
                        state_nxt = PENC_SCAN;
                    end else begin
                        state_nxt = PENC_ZERO;
                    end
                end
            end
            PENC_SCAN: begin
                out_valid = 1'b1;
                out_idx   = enc_idx;
                out_last  = enc_single;
                if (out_ready) begin
                    pend_nxt = pend & (pend - N_IN'(1));
                    if (enc_single) state_nxt = PENC_IDLE;
                end
            end
            PENC_ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_none  = 1'b1;
                if (out_ready) state_nxt = PENC_IDLE;
            end
            default: state_nxt = PENC_IDLE;
        endcase
    end

`ifdef PENC_COUNT_EN
    function automatic logic [IDX_W:0] popcount(input logic [N_IN-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) c = c + {{IDX_W{1'b0}}, v[i]};
        return c;
    endfunction

    logic [IDX_W:0] cnt;

    // Loaded only on acceptance, so it stays constant across the whole burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (accept) cnt <= popcount(in_vec);
    end

    assign out_cnt = cnt;
`else
    // Without the count option there is no cnt register and no popcount logic.
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder (N_IN=16 and N_IN=5 instances);
// works with or without PENC_COUNT_EN defined.
`timescale 1ns/1ps
module tb_seq_priority_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, out_none;
    logic [15:0] in_vec;
    logic [3:0]  out_idx;
    logic        in_valid_5, in_ready_5, out_valid_5, out_ready_5, out_last_5, out_none_5;
    logic [4:0]  in_vec_5;
    logic [2:0]  out_idx_5;
`ifdef PENC_COUNT_EN
    logic [4:0]  out_cnt;
    logic [3:0]  out_cnt_5;
`endif

    seq_priority_encoder #(.N_IN(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_none(out_none)
`ifdef PENC_COUNT_EN
        , .out_cnt(out_cnt)
`endif
    );

    seq_priority_encoder #(.N_IN(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid_5), .in_ready(in_ready_5), .in_vec(in_vec_5),
        .out_valid(out_valid_5), .out_ready(out_ready_5), .out_idx(out_idx_5),
        .out_last(out_last_5), .out_none(out_none_5)
`ifdef PENC_COUNT_EN
        , .out_cnt(out_cnt_5)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: list of set-bit positions of the vector, ascending.
    task automatic build_model(input logic [15:0] v, input int width);
        exp_q.delete();
        for (int i = 0; i < width; i++) if (v[i]) exp_q.push_back(i);
    endtask

    task automatic burst16(input logic [15:0] v, input int hold, input bit rand_rdy,
                           input bit drop_en, output int beats, output int first_idx,
                           output int last_idx, output int none_seen);
        int pc, cyc, waited, n_exp;
        bit zero;
        build_model(v, 16);
        pc        = exp_q.size();
        zero      = (pc == 0);
        n_exp     = zero ? 1 : pc;
        beats     = 0;
        first_idx = -1;
        last_idx  = -1;
        none_seen = 0;
        waited    = 0;
        @(negedge clk);
        in_vec   = v;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
        if (drop_en) enable = 1'b0;
        cyc = 0;
        while (beats < n_exp && cyc < 200) begin
            @(negedge clk);
            if (cyc < hold)    out_ready = 1'b0;
            else if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1) || (waited >= 4);
            else               out_ready = 1'b1;
            check("out_valid", out_valid, 1);
            if (zero) begin
                check("out_idx", out_idx, 0);
                check("out_last", out_last, 1);
            end else begin
                check("out_idx", out_idx, exp_q[0]);
                check("out_last", out_last, int'(exp_q.size() == 1));
            end
            check("out_none", out_none, int'(zero));
`ifdef PENC_COUNT_EN
            check("out_cnt", out_cnt, pc);
`endif
            check("in_ready_busy", in_ready, 0);
            if (out_ready) begin
                if (beats == 0) first_idx = out_idx;
                last_idx = out_idx;
                if (out_none) none_seen = 1;
                beats++;
                if (!zero) void'(exp_q.pop_front());
                waited = 0;
            end else begin
                waited++;
            end
            cyc++;
        end
        if (beats < n_exp) check("burst_timeout", beats, n_exp);
        @(negedge clk);
        check("gap_out_valid", out_valid, 0);
        if (drop_en) begin
            check("gap_in_ready_en0", in_ready, 0);
            enable = 1'b1;
            #1;
        end
        check("gap_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [15:0] vec;
        int          beats;
        int          first;
        int          last;
        int          none;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected %0d", 0);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, f, l, nn;
        logic [15:0] v;
        logic [4:0]  v5;

        tbl[0] = '{16'h0004,  1,  2,  2, 0};
        tbl[1] = '{16'h1040,  2,  6, 12, 0};
        tbl[2] = '{16'h8001,  2,  0, 15, 0};
        tbl[3] = '{16'h0000,  1,  0,  0, 1};
        tbl[4] = '{16'h0400,  1, 10, 10, 0};
        tbl[5] = '{16'hFFFF, 16,  0, 15, 0};
        tbl[6] = '{16'h8000,  1, 15, 15, 0};
        tbl[7] = '{16'hA5A5,  8,  0, 15, 0};
        tbl[8] = '{16'h0006,  2,  1,  2, 0};

        rst_n = 1'b0; enable = 1'b1;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        in_valid_5 = 1'b0; in_vec_5 = '0; out_ready_5 = 1'b1;

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_none", out_none, 0);
        check("rst5_in_ready", in_ready_5, 0);
        check("rst5_out_valid", out_valid_5, 0);
`ifdef PENC_COUNT_EN
        check("rst_out_cnt", out_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            burst16(tbl[i].vec, 0, 1'b0, 1'b0, b, f, l, nn);
            check($sformatf("tbl%0d_beats", i), b, tbl[i].beats);
            check($sformatf("tbl%0d_first", i), f, tbl[i].first);
            check($sformatf("tbl%0d_last", i), l, tbl[i].last);
            check($sformatf("tbl%0d_none", i), nn, tbl[i].none);
        end

        burst16(16'h8001, 5, 1'b0, 1'b0, b, f, l, nn);
        check("bp_beats", b, 2);
        check("bp_first", f, 0);
        check("bp_last", l, 15);

        @(negedge clk);
        enable = 1'b0; in_valid = 1'b1; in_vec = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en0_in_ready", in_ready, 0);
            check("en0_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        enable = 1'b1;

        burst16(16'h0400, 3, 1'b0, 1'b1, b, f, l, nn);
        check("endrop_beats", b, 1);
        check("endrop_idx", f, 10);

        @(negedge clk);
        out_ready = 1'b1;
        in_vec = 16'hFFFF; in_valid = 1'b1;
        check("rstb_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstb_idx", out_idx, i);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rstb_out_valid", out_valid, 0);
        check("rstb_in_ready", in_ready, 0);
        check("rstb_out_idx", out_idx, 0);
        check("rstb_out_last", out_last, 0);
        check("rstb_out_none", out_none, 0);
`ifdef PENC_COUNT_EN
        check("rstb_out_cnt", out_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstb_idle_valid", out_valid, 0);
        check("rstb_idle_ready", in_ready, 1);
        burst16(16'h0004, 0, 1'b0, 1'b0, b, f, l, nn);
        check("rstb_after_beats", b, 1);
        check("rstb_after_idx", f, 2);

        for (int k = 0; k < 40; k++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'h0001 << $urandom_range(0, 15);
                2:       v = v & 16'($urandom);
                default: ;
            endcase
            burst16(v, $urandom_range(0, 3), 1'b1, 1'b0, b, f, l, nn);
            check("rand_beats", b, (v == 16'h0000) ? 1 : $countones(v));
            check("rand_none", nn, int'(v == 16'h0000));
        end

        for (int k = 0; k < 6; k++) begin
            v5 = (k == 0) ? 5'b10010 : 5'($urandom_range(1, 31));
            build_model(16'(v5), 5);
            @(negedge clk);
            in_vec_5 = v5; in_valid_5 = 1'b1; out_ready_5 = 1'b1;
            check("n5_in_ready", in_ready_5, 1);
            @(posedge clk);
            #1;
            in_valid_5 = 1'b0;
            for (int j = 0; j < exp_q.size(); j++) begin
                @(negedge clk);
                check("n5_out_valid", out_valid_5, 1);
                check("n5_out_idx", out_idx_5, exp_q[j]);
                check("n5_out_last", out_last_5, int'(j == exp_q.size() - 1));
                check("n5_out_none", out_none_5, 0);
`ifdef PENC_COUNT_EN
                check("n5_out_cnt", out_cnt_5, exp_q.size());
`endif
            end
            @(negedge clk);
            check("n5_gap_valid", out_valid_5, 0);
            check("n5_gap_ready", in_ready_5, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
